sub64_seq: RTL and testbench
============================

Name: sub64_seq

Overview:
Multi-cycle 64-bit subtractor, the inverse companion of the team's 64-bit ripple-carry adder. It computes a − b − b_in one CHUNK-bit slice per clock, starting from the LSB slice and rippling the borrow between slices through a register. It provides a start/busy/done handshake and result flags (borrow, signed overflow, zero). It sits beside the adder in the datapath where a registered, low-area subtract/compare is acceptable.

Parameters:
WIDTH, 64, operand and result width in bits
CHUNK, 16, bits processed per cycle; WIDTH must be an integer multiple of CHUNK (4 slices at default)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while idle (busy=0)
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
b_in  input  1  borrow in; captured on accepted start
busy  output  1  high while slices are being computed
done  output  1  one-cycle pulse; results valid from this cycle on
diff  output  WIDTH  (a − b − b_in) mod 2^WIDTH
b_out  output  1  borrow out: 1 iff unsigned a < b + b_in
ovf  output  1  1 iff signed (two's complement) a − b − b_in is not representable in WIDTH bits
zero  output  1  1 iff diff == 0

Behaviour:
- Reset (rst=1 at a clock edge): busy=0, done=0, diff=0, b_out=0, ovf=0, zero=0. Slice counter and internal borrow are cleared. Reset overrides everything, including an in-flight operation, which is discarded with no done pulse.
- States:
  - IDLE (busy=0)
  - RUN (busy=1)
  - Done is a pulse emitted on the return to IDLE, not a separate state.
- IDLE → RUN: at an edge where start=1 and busy=0.
  - a, b and b_in are latched; counter=0; the internal carry is set to ~b_in.
  - diff and the flags are cleared at this edge.
- RUN, one slice per edge, for slice k = counter:
  - {c, d} = a[k] + ~b[k] + carry, where each operand is a CHUNK-bit field.
  - d is written to diff[k*CHUNK +: CHUNK]; carry ← c; counter ← counter+1.
  - No other bits of diff change.
- Last slice edge (counter = WIDTH/CHUNK−1):
  - Return to IDLE; busy←0; done←1 for exactly one cycle.
  - b_out ← ~final carry.
  - ovf ← carry into MSB XOR carry out of MSB.
  - zero ← (full diff == 0).
- Latency: with start sampled at edge E0, done is high during the cycle following edge E(WIDTH/CHUNK), i.e. E4 at default. busy is high from E0 to E4.
- Results hold after done until the next accepted start or reset.
- start while busy=1: ignored; no queuing and no effect on the operation.
- Operand changes while busy: ignored, because the latched copies are used.
- start high in the done cycle: accepted, since busy=0. This gives back-to-back operations at a throughput of one per WIDTH/CHUNK+1 cycles.
- start held high continuously: operations repeat back-to-back, each using the operand values present at its own accept edge.
- Intermediate diff contents while busy=1 are not guaranteed stable. Consumers sample only on or after done.
- Widths: all arithmetic is modulo 2^WIDTH; there is no sign extension. Signed interpretation affects only ovf.

Test Plan:
- Basic subtract: a=5, b=3, b_in=0 → after 4 cycles done=1, diff=2, b_out=0, ovf=0, zero=0. Check busy high for exactly 4 cycles.
- Underflow and borrow-in: a=0, b=1, b_in=0 → diff=0xFFFF_FFFF_FFFF_FFFF, b_out=1, ovf=0. Then a=b=0x1234, b_in=1 → diff=all ones, b_out=1. Then a=b=0x1234, b_in=0 → diff=0, zero=1, b_out=0.
- Cross-slice borrow ripple:
  - a=0x0000_0000_0001_0000, b=1 → diff=0x0000_0000_0000_FFFF.
  - a=0x1_0000_0000_0000 (bit 48 set), b=1 → diff=0x0000_FFFF_FFFF_FFFF; borrow propagates through 3 slices.
- Signed overflow:
  - a=0x8000_0000_0000_0000, b=1 → diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, b_out=0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF → diff=0x8000_0000_0000_0000, ovf=1, b_out=1.
- Handshake edge cases:
  - Pulse start again on cycle 2 of RUN with different operands → ignored; first result unchanged.
  - Hold start high through done → a second operation starts in the done cycle, with its done 5 cycles after the first.
  - Change a/b mid-RUN → result reflects the latched values.
- Reset mid-operation: assert rst on cycle 2 of RUN → next cycle busy=0, done=0, diff=0, all flags 0, no done pulse. A new start afterwards completes correctly, e.g. 10−4=6.

Source files
------------

// File: rtl/sub64_seq.sv
// Multi-cycle subtractor: computes a - b - b_in one CHUNK-bit slice per clock,
// LSB slice first, with a registered borrow chain and start/busy/done handshake.
module sub64_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICES = WIDTH / CHUNK;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [31:0]      shamt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK-1:0] d_s;
    logic             c_s;
    logic [WIDTH-1:0] diff_nxt;
    logic             ovf_nxt;

    assign busy = (state == S_RUN);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        shamt    = 32'(cnt) * 32'(CHUNK);
        a_shift  = a_q >> shamt;
        b_shift  = b_q >> shamt;
        a_s      = a_shift[CHUNK-1:0];
        b_s      = b_shift[CHUNK-1:0];
        {c_s, d_s} = {1'b0, a_s} + {1'b0, ~b_s} + {{CHUNK{1'b0}}, carry};
        diff_nxt = (diff & ~(SLICE_MASK << shamt)) | (WIDTH'(d_s) << shamt);
        // Carry-in XOR carry-out of the MSB, expressed through the operand and result signs.
        ovf_nxt  = (a_s[CHUNK-1] != b_s[CHUNK-1]) && (d_s[CHUNK-1] != a_s[CHUNK-1]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            done  <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        carry <= ~b_in;
                        cnt   <= '0;
                        diff  <= '0;
                        b_out <= 1'b0;
                        ovf   <= 1'b0;
                        zero  <= 1'b0;
                    end
                end
                S_RUN: begin
                    diff  <= diff_nxt;
                    carry <= c_s;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_SLICE) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        b_out <= ~c_s;
                        ovf   <= ovf_nxt;
                        zero  <= (diff_nxt == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: operand copies are pure datapath loaded on every accepted start,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        if (!busy && start) begin
            a_q <= a;
            b_q <= b;
        end
    end

endmodule

// File: tb/tb_sub64_seq.sv
// Self-checking bench for sub64_seq: directed corner cases, random operands
// against an arithmetic reference model, and handshake/reset scenarios.
module tb_sub64_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        b_in;
    logic        busy;
    logic        done;
    logic [63:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    sub64_seq #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain wide arithmetic on the unsigned and signed values.
    function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                                  output logic [63:0] md, output logic mbo, output logic mov,
                                  output logic mz);
        logic signed [65:0] s;
        md  = ma - mb - 64'(mbin);
        mbo = ({1'b0, ma} < ({1'b0, mb} + 65'(mbin)));
        s   = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb}) - $signed(66'(mbin));
        mov = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
        mz  = (md == 64'd0);
    endfunction

    // Launch one operation and wait (bounded) for done; leaves time in the done cycle.
    task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic ibin,
                          output int busy_cyc, output bit got_done);
        @(negedge clk);
        a = ia; b = ib; b_in = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %h want 0", done); end
        n_checks++; if (diff !== 64'd0)  begin n_fail++; $display("FAIL reset_diff: got %h want 0", diff); end
        n_checks++; if ({b_out, ovf, zero} !== 3'b000)
            begin n_fail++; $display("FAIL reset_flags: got %b want 000", {b_out, ovf, zero}); end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        int   bc;
        bit   ok;
        v[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        v[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        v[2] = '{64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        v[3] = '{64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        v[4] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0};
        v[5] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        v[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        v[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
        v[8] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        v[9] = '{64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        foreach (v[i]) begin
            run_op(v[i].a, v[i].b, v[i].bin, bc, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL dir%0d_done: no done within bound", i); end
            n_checks++; if (bc != 4) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d want 4", i, bc); end
            n_checks++; if (diff !== v[i].d) begin n_fail++; $display("FAIL dir%0d_diff: got %h want %h", i, diff, v[i].d); end
            n_checks++; if ({b_out, ovf, zero} !== {v[i].bo, v[i].ov, v[i].z})
                begin n_fail++; $display("FAIL dir%0d_flags(bo,ovf,z): got %b want %b", i, {b_out, ovf, zero}, {v[i].bo, v[i].ov, v[i].z}); end
            if (i == 0) begin
                repeat (3) @(negedge clk);
                n_checks++; if (diff !== v[0].d || done !== 1'b0)
                    begin n_fail++; $display("FAIL hold_after_done: got diff=%h done=%b want diff=%h done=0", diff, done, v[0].d); end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] ra, rb, ed;
        logic        rbin, ebo, eov, ez;
        int          bc;
        bit          ok;
        for (int i = 0; i < 30; i++) begin
            ra   = {$urandom, $urandom};
            rb   = ($urandom_range(0, 4) == 0) ? ra : {$urandom, $urandom};
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, ed, ebo, eov, ez);
            run_op(ra, rb, rbin, bc, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_done: no done within bound", i); end
            n_checks++; if (diff !== ed) begin n_fail++; $display("FAIL rnd%0d_diff: got %h want %h", i, diff, ed); end
            n_checks++; if ({b_out, ovf, zero} !== {ebo, eov, ez})
                begin n_fail++; $display("FAIL rnd%0d_flags(bo,ovf,z): got %b want %b", i, {b_out, ovf, zero}, {ebo, eov, ez}); end
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [63:0] ed;
        logic        ebo, eov, ez;
        int          bc;
        bit          ok;
        model(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b0, ed, ebo, eov, ez);
        @(negedge clk);
        a = 64'h0123_4567_89AB_CDEF; b = 64'h0FED_CBA9_8765_4321; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = busy ? 1 : 0;
        @(negedge clk);
        bc += busy ? 1 : 0;
        // Second cycle of RUN: new request and new operands must both be ignored.
        start = 1'b1; a = 64'hDEAD_BEEF_0000_0001; b = 64'h1; b_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (busy) bc++;
            @(negedge clk);
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_done: no done within bound"); end
        n_checks++; if (bc != 4) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d want 4", bc); end
        n_checks++; if (diff !== ed) begin n_fail++; $display("FAIL ignore_diff: got %h want %h", diff, ed); end
        n_checks++; if ({b_out, ovf, zero} !== {ebo, eov, ez})
            begin n_fail++; $display("FAIL ignore_flags: got %b want %b", {b_out, ovf, zero}, {ebo, eov, ez}); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_requeue: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ed1, ed2;
        logic        bo1, ov1, z1, bo2, ov2, z2;
        int          t1, t2;
        model(64'd1000, 64'd1, 1'b0, ed1, bo1, ov1, z1);
        model(64'h5555_0000_0000_0000, 64'h6666_0000_0000_0001, 1'b1, ed2, bo2, ov2, z2);
        t1 = -1; t2 = -1;
        @(negedge clk);
        a = 64'd1000; b = 64'd1; b_in = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 40 && t2 < 0; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    n_checks++; if ({diff, b_out, ovf, zero} !== {ed1, bo1, ov1, z1})
                        begin n_fail++; $display("FAIL b2b_first: got %h/%b want %h/%b", diff, {b_out, ovf, zero}, ed1, {bo1, ov1, z1}); end
                    a = 64'h5555_0000_0000_0000; b = 64'h6666_0000_0000_0001; b_in = 1'b1;
                end else begin
                    t2 = cyc;
                    n_checks++; if ({diff, b_out, ovf, zero} !== {ed2, bo2, ov2, z2})
                        begin n_fail++; $display("FAIL b2b_second: got %h/%b want %h/%b", diff, {b_out, ovf, zero}, ed2, {bo2, ov2, z2}); end
                end
            end
        end
        start = 1'b0;
        n_checks++; if (t1 != 4) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 4", t1); end
        n_checks++; if (t2 < 0 || (t2 - t1) != 5) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 5", t2 - t1); end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        int bc;
        bit ok;
        @(negedge clk);
        a = 64'd100; b = 64'd1; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rstmid_busy_done: got %b want 00", {busy, done}); end
        n_checks++; if (diff !== 64'd0) begin n_fail++; $display("FAIL rstmid_diff: got %h want 0", diff); end
        n_checks++; if ({b_out, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b want 000", {b_out, ovf, zero}); end
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
        run_op(64'd10, 64'd4, 1'b0, bc, ok);
        n_checks++; if (!ok || diff !== 64'd6) begin n_fail++; $display("FAIL rstmid_after: got done=%b diff=%h want done=1 diff=6", ok, diff); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
